// File: rtl/hybrid_psum_accumulator.sv
// Unpacks packed psum words into 1/2/4 signed lanes and accumulates each lane over cfg_len beats.
// Optional: define PSUM_ACC_SAT_EN for saturating lane adds (default is two's-complement wrap).
module hpa_lane #(
    parameter int ACC_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             add_i,
    input  logic [ACC_W-1:0] val_i,
    output logic [ACC_W-1:0] acc_o
);
    logic [ACC_W-1:0] acc_q, acc_d;

`ifdef PSUM_ACC_SAT_EN
    // one guard bit exposes signed overflow of the add
    logic [ACC_W:0] sum;
    assign sum = {acc_q[ACC_W-1], acc_q} + {val_i[ACC_W-1], val_i};

    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (add_i) begin
            if (sum[ACC_W] != sum[ACC_W-1])
                acc_d = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
            else
                acc_d = sum[ACC_W-1:0];
        end
    end
`else
    always_comb begin
        acc_d = acc_q;
        if (clr_i)      acc_d = '0;
        else if (add_i) acc_d = acc_q + val_i;
    end
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) acc_q <= '0;
        else         acc_q <= acc_d;
    end

    assign acc_o = acc_q;
endmodule

module hybrid_psum_accumulator #(
    parameter int PSUM_W = 24,
    parameter int ACC_W  = 32,
    parameter int CNT_W  = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               cfg_valid_i,
    output logic               cfg_ready_o,
    input  logic [3:0]         cfg_quant_size_i,
    input  logic [CNT_W-1:0]   cfg_len_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [PSUM_W-1:0]  in_psum_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [4*ACC_W-1:0] out_data_o,
    output logic [2:0]         out_lanes_o
);
    localparam int L2 = PSUM_W / 2;
    localparam int L4 = PSUM_W / 4;
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_e;

    state_e                  state_q, state_d;
    logic [3:0]              q_q, q_d;
    logic [CNT_W-1:0]        len_q, len_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [3:0][ACC_W-1:0]   lane_val;
    logic [3:0][ACC_W-1:0]   acc;
    logic                    cfg_fire, beat, last;

    assign cfg_fire = (state_q == IDLE)  && cfg_valid_i;
    assign beat     = (state_q == ACCUM) && in_valid_i;
    assign last     = beat && (cnt_q == len_q - ONE);

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (cfg_valid_i) begin
                q_d     = cfg_quant_size_i;
                len_d   = cfg_len_i;
                cnt_d   = '0;
                state_d = (cfg_len_i == '0) ? DONE : ACCUM;
            end
            ACCUM: if (beat) begin
                cnt_d = cnt_q + ONE;
                if (last) state_d = DONE;
            end
            DONE: if (out_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            q_q     <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
        end
    end

    // illegal quant sizes leave every lane at zero so beats are consumed harmlessly
    always_comb begin
        lane_val = '0;
        case (q_q)
            4'd8: lane_val[0] = ACC_W'($signed(in_psum_i));
            4'd4: for (int i = 0; i < 2; i++)
                      lane_val[i] = ACC_W'($signed(in_psum_i[i*L2 +: L2]));
            4'd2: for (int i = 0; i < 4; i++)
                      lane_val[i] = ACC_W'($signed(in_psum_i[i*L4 +: L4]));
            default: lane_val = '0;
        endcase
    end

    for (genvar g = 0; g < 4; g++) begin : g_lane
        hpa_lane #(.ACC_W(ACC_W)) u_lane (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .clr_i  (cfg_fire),
            .add_i  (beat),
            .val_i  (lane_val[g]),
            .acc_o  (acc[g])
        );
    end

    always_comb begin
        case (q_q)
            4'd8:    out_lanes_o = 3'd1;
            4'd4:    out_lanes_o = 3'd2;
            4'd2:    out_lanes_o = 3'd4;
            default: out_lanes_o = 3'd0;
        endcase
    end

    assign cfg_ready_o = (state_q == IDLE);
    assign in_ready_o  = (state_q == ACCUM);
    assign out_valid_o = (state_q == DONE);
    assign out_data_o  = acc;
endmodule
